// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared types and constants for the matrix-vector engine
// Contents: sequencer state enum mv_state_t, engine geometry constants and the
// word address of the B vector (it follows the NUM_ROWS A rows).
package matvec_pkg;

    localparam int NUM_ROWS    = 8;
    localparam int DATA_WIDTH  = 8;
    localparam int WORD_WIDTH  = NUM_ROWS * DATA_WIDTH;
    localparam int ADDR_WIDTH  = 32;
    localparam int B_WORD_ADDR = NUM_ROWS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FLUSH,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } mv_state_t;

endpackage

// File: rtl/word_unpacker.sv
// rtl/word_unpacker.sv - latches one memory word and serves it byte by byte
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            capture word_i (read data valid in the WAIT state)
//   word_i            memory read data
//   advance_i         current byte was accepted by its FIFO; step to the next
//   byte_o            byte k of the latched word, k=0 is the least significant
//   last_byte_o       byte k is the final byte of the word
module word_unpacker #(
    parameter int NUM_BYTES  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_i,
    input  logic [NUM_BYTES*DATA_WIDTH-1:0] word_i,
    input  logic                            advance_i,
    output logic [DATA_WIDTH-1:0]           byte_o,
    output logic                            last_byte_o
);

    localparam int KW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic [NUM_BYTES*DATA_WIDTH-1:0] word_q;
    logic [KW-1:0]                   k_q;
    logic [DATA_WIDTH-1:0]           lanes [NUM_BYTES];

    assign last_byte_o = (k_q == KW'(NUM_BYTES - 1));

    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            lanes[i] = word_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        byte_o = lanes[k_q];
    end

    // k only moves on an accepted write, so a stalled byte stays presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            k_q    <= '0;
        end else begin
            if (load_i) begin
                word_q <= word_i;
            end
            if (advance_i) begin
                k_q <= last_byte_o ? '0 : k_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matvec_sequencer.sv
// rtl/matvec_sequencer.sv - fetches A rows and B vector, fills FIFOs, runs the MAC chain
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start / busy / done            run request, activity flag, completion pulse
//   avm_*                          Avalon-MM read master (one outstanding read)
//   fifo_clr                       flush pulse to all input FIFOs
//   fifo_wdata, fifo_wrreq_a/_b    shared write data and per-FIFO write requests
//   fifo_wrfull_a/_b               FIFO full flags, gate the write requests
//   fifo_rdempty_b                 B FIFO empty, gates mac_en
//   mac_clr, mac_en                accumulator clear and chain enable
module matvec_sequencer #(
    parameter int NUM_ROWS   = matvec_pkg::NUM_ROWS,
    parameter int DATA_WIDTH = matvec_pkg::DATA_WIDTH,
    parameter int WORD_WIDTH = matvec_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = matvec_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic [WORD_WIDTH-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest,
    output logic                  fifo_clr,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic [NUM_ROWS-1:0]   fifo_wrreq_a,
    output logic                  fifo_wrreq_b,
    input  logic [NUM_ROWS-1:0]   fifo_wrfull_a,
    input  logic                  fifo_wrfull_b,
    input  logic                  fifo_rdempty_b,
    output logic                  mac_clr,
    output logic                  mac_en
);

    import matvec_pkg::*;

    localparam logic [3:0] LAST_WORD = 4'(NUM_ROWS);
    localparam logic [3:0] LAST_MAC  = 4'(NUM_ROWS - 1);
    localparam logic [3:0] LAST_DRN  = 4'(NUM_ROWS);

    mv_state_t             state_q;
    logic [3:0]            word_q;
    logic [3:0]            mac_cnt_q;
    logic [3:0]            drain_q;

    logic                  in_push;
    logic                  word_is_b;
    logic [NUM_ROWS-1:0]   row_sel;
    logic                  byte_accept;
    logic                  last_byte;
    logic                  word_load;
    logic [DATA_WIDTH-1:0] cur_byte;

    assign in_push   = (state_q == S_PUSH);
    assign word_is_b = (word_q == LAST_WORD);
    assign word_load = (state_q == S_WAIT) && avm_readdatavalid;

    // Row select is all-zero for the B word, so A requests stay quiet then.
    always_comb begin
        for (int i = 0; i < NUM_ROWS; i++) begin
            row_sel[i] = (word_q == 4'(i));
        end
        fifo_wrreq_a = in_push ? (row_sel & ~fifo_wrfull_a) : '0;
        fifo_wrreq_b = in_push && word_is_b && !fifo_wrfull_b;
        byte_accept  = (|fifo_wrreq_a) || fifo_wrreq_b;
    end

    word_unpacker #(
        .NUM_BYTES  (NUM_ROWS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_unpacker (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (word_load),
        .word_i      (avm_readdata),
        .advance_i   (byte_accept),
        .byte_o      (cur_byte),
        .last_byte_o (last_byte)
    );

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign fifo_clr    = (state_q == S_FLUSH);
    assign mac_clr     = (state_q == S_CLR);
    assign avm_read    = (state_q == S_REQ);
    assign avm_address = ADDR_WIDTH'(word_q);
    assign fifo_wdata  = in_push ? cur_byte : '0;
    assign mac_en      = (state_q == S_RUN) && !fifo_rdempty_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            mac_cnt_q <= '0;
            drain_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    word_q  <= '0;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (!avm_waitrequest) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (avm_readdatavalid) begin
                        state_q <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (byte_accept && last_byte) begin
                        if (word_is_b) begin
                            state_q <= S_CLR;
                        end else begin
                            word_q  <= word_q + 4'd1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_CLR: begin
                    mac_cnt_q <= '0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    // Only cycles where B data was actually consumed count.
                    if (mac_en) begin
                        if (mac_cnt_q == LAST_MAC) begin
                            drain_q <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            mac_cnt_q <= mac_cnt_q + 4'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Covers the chain skew plus the final MAC register stage.
                    if (drain_q == LAST_DRN) begin
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_sequencer.sv
// tb/tb_matvec_sequencer.sv - scoreboard bench for matvec_sequencer
module tb_matvec_sequencer;

    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, avm_read;
    logic [31:0] avm_address;
    logic [63:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        avm_waitrequest;
    logic        fifo_clr;
    logic [7:0]  fifo_wdata;
    logic [7:0]  fifo_wrreq_a;
    logic        fifo_wrreq_b;
    logic [7:0]  fifo_wrfull_a = '0;
    logic        fifo_wrfull_b = 1'b0;
    logic        fifo_rdempty_b = 1'b0;
    logic        mac_clr, mac_en;

    always #5 clk = ~clk;

    matvec_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest),
        .fifo_clr          (fifo_clr),
        .fifo_wdata        (fifo_wdata),
        .fifo_wrreq_a      (fifo_wrreq_a),
        .fifo_wrreq_b      (fifo_wrreq_b),
        .fifo_wrfull_a     (fifo_wrfull_a),
        .fifo_wrfull_b     (fifo_wrfull_b),
        .fifo_rdempty_b    (fifo_rdempty_b),
        .mac_clr           (mac_clr),
        .mac_en            (mac_en)
    );

    logic [63:0] mem [NR+1];
    int          ws_tab [NR+1];
    int          ws_used = 0;

    int          exp_tgt [$];
    logic [7:0]  exp_dat [$];
    int          exp_addr [$];

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    exp_lat = -1;
    int    n_done = 0, n_mac = 0, n_read = 0, wr_count = 0;
    int    base_done = 0, base_mac = 0, base_read = 0, base_wr = 0;
    int    start_seq = 0;
    bit    rand_full = 0, rand_empty = 0;
    int    stall_at = -1, stall_len = 0;
    int    empty_after = -1, empty_len = 0;
    int    start_at_mac = -1;
    string tname = "reset";

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        avm_waitrequest = 1'b0;
        if (avm_read && avm_address <= 32'(NR)) begin
            avm_waitrequest = (ws_used < ws_tab[int'(avm_address)]);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", tname, name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        check(name, {busy, done, avm_read, fifo_clr, fifo_wrreq_a, fifo_wrreq_b,
                     mac_clr, mac_en, avm_address, fifo_wdata}, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a transaction.
    always @(negedge clk) begin : monitor
        int tgt;
        if (rst_n) begin
            if (fifo_wrreq_a != 8'd0 || fifo_wrreq_b) begin
                tgt = -1;
                for (int i = 0; i < NR; i++) if (fifo_wrreq_a[i]) tgt = i;
                if (fifo_wrreq_b) tgt = NR;
                check("wr_onehot", $countones(fifo_wrreq_a) + int'(fifo_wrreq_b), 1);
                check("wr_gate", {fifo_wrreq_a & fifo_wrfull_a, fifo_wrreq_b & fifo_wrfull_b}, 0);
                if (exp_tgt.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    check("wr_target", tgt, exp_tgt.pop_front());
                    check("wr_data", fifo_wdata, exp_dat.pop_front());
                end
                wr_count++;
            end
            if (avm_read) begin
                n_read++;
                if (!avm_waitrequest) begin
                    if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
                    else check("rd_addr", avm_address, exp_addr.pop_front());
                end
            end
            if (mac_en) begin
                n_mac++;
                check("mac_en_gate", fifo_rdempty_b, 0);
            end
            if (fifo_clr) check("clr_cycle", cyc - start_cyc, 1);
            if (done) begin
                n_done++;
                if (exp_lat >= 0) check("latency", cyc - start_cyc, exp_lat);
            end
        end
    end

    // Driver: memory slave, FIFO flags and start, all updated just after posedge.
    initial begin : driver
        bit acc, waited;
        int acc_addr, stall_cnt, empty_cnt, seen_seq;
        bit inrun_done;
        stall_cnt = 0; empty_cnt = 0; seen_seq = 0; inrun_done = 0;
        forever begin
            @(negedge clk);
            acc      = rst_n && avm_read && !avm_waitrequest;
            waited   = rst_n && avm_read && avm_waitrequest;
            acc_addr = int'(avm_address);
            @(posedge clk);
            #1;
            if (!rst_n) begin
                avm_readdatavalid = 1'b0;
                ws_used = 0;
            end else if (acc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = (acc_addr <= NR) ? mem[acc_addr] : '0;
                ws_used = 0;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = {$urandom, $urandom};
                if (waited) ws_used++;
            end
            if (start_seq != seen_seq) begin
                seen_seq = start_seq;
                start = 1'b1;
                start_cyc = cyc;
                stall_cnt = 0; empty_cnt = 0; inrun_done = 0;
            end else if (start_at_mac >= 0 && !inrun_done && n_mac - base_mac == start_at_mac) begin
                start = 1'b1;
                inrun_done = 1;
            end else begin
                start = 1'b0;
            end
            fifo_wrfull_a = rand_full ? 8'($urandom & $urandom) : 8'd0;
            fifo_wrfull_b = rand_full && ($urandom_range(0, 3) == 0);
            if (stall_at >= 0 && wr_count - base_wr == stall_at && stall_cnt < stall_len) begin
                if (stall_at / 8 < NR) fifo_wrfull_a[stall_at / 8] = 1'b1;
                else fifo_wrfull_b = 1'b1;
                stall_cnt++;
            end
            if (rand_empty) begin
                fifo_rdempty_b = ($urandom_range(0, 2) == 0);
            end else if (empty_after >= 0 && n_mac - base_mac == empty_after && empty_cnt < empty_len) begin
                fifo_rdempty_b = 1'b1;
                empty_cnt++;
            end else begin
                fifo_rdempty_b = 1'b0;
            end
        end
    end

    // Reference model: word w feeds FIFO w (B for w==NR), bytes LSB first.
    task automatic prepare(input bit pattern, input int lat);
        for (int w = 0; w <= NR; w++) begin
            mem[w] = pattern ? 64'h0807060504030201 + 64'(w) * 64'h0101010101010101
                             : {$urandom, $urandom};
            exp_addr.push_back(w);
            for (int k = 0; k < 8; k++) begin
                exp_tgt.push_back(w);
                exp_dat.push_back(mem[w][8*k +: 8]);
            end
        end
        exp_lat   = lat;
        base_done = n_done;
        base_mac  = n_mac;
        base_read = n_read;
        base_wr   = wr_count;
        @(negedge clk);
        start_seq++;
    endtask

    task automatic finish_run();
        int t;
        int ws_sum;
        t = 0;
        ws_sum = 0;
        while (n_done == base_done && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_timeout", n_done != base_done, 1);
        repeat (10) begin
            @(negedge clk);
            #1;
        end
        check("done_count", n_done - base_done, 1);
        check("busy_idle", busy, 0);
        check("mac_en_count", n_mac - base_mac, NR);
        for (int w = 0; w <= NR; w++) ws_sum += ws_tab[w];
        check("read_cycles", n_read - base_read, NR + 1 + ws_sum);
        check("sb_empty", exp_tgt.size() + exp_addr.size(), 0);
    endtask

    task automatic clear_modes();
        for (int w = 0; w <= NR; w++) ws_tab[w] = 0;
        rand_full = 0; rand_empty = 0;
        stall_at = -1; stall_len = 0;
        empty_after = -1; empty_len = 0;
        start_at_mac = -1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        int t;
        clear_modes();
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset_outputs");
        rst_n = 1'b1;

        tname = "zero_wait";
        prepare(1, 110);
        finish_run();

        tname = "waitrequest";
        clear_modes();
        ws_tab[4] = 3;
        prepare(1, 113);
        finish_run();

        tname = "full_stall";
        clear_modes();
        stall_at = 2 * 8 + 3;
        stall_len = 5;
        prepare(0, 115);
        finish_run();

        tname = "b_empty";
        clear_modes();
        empty_after = 3;
        empty_len = 2;
        prepare(0, 112);
        finish_run();

        tname = "mid_reset";
        clear_modes();
        prepare(0, -1);
        t = 0;
        while (wr_count - base_wr < 5 * 8 + 2 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reached_word5", wr_count - base_wr >= 5 * 8 + 2, 1);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk_zero("mid_reset_outputs");
        end
        exp_tgt.delete();
        exp_dat.delete();
        exp_addr.delete();
        rst_n = 1'b1;
        tname = "after_reset";
        prepare(1, 110);
        finish_run();

        tname = "start_in_run";
        clear_modes();
        start_at_mac = 2;
        prepare(0, 110);
        finish_run();

        for (int r = 0; r < 6; r++) begin
            tname = $sformatf("random%0d", r);
            clear_modes();
            for (int w = 0; w <= NR; w++) ws_tab[w] = $urandom_range(0, 2);
            rand_full = 1;
            rand_empty = 1;
            prepare(0, -1);
            finish_run();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
